load_store_unit: RTL and testbench

- Sits between the single-cycle datapath (ALU address result, rt store data, load/store control) and the word-organised data memory.
- Converts byte, halfword and word loads and stores into aligned 32-bit word accesses, little-endian lane order.
- Sub-word stores use read-modify-write; loads are zero- or sign-extended.
- Accepts requests and returns responses over a valid/ready handshake, so the core stalls while an access is outstanding.

---
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests from the datapath into
// aligned 32-bit word accesses on a small word-organised data memory.
// Sub-word stores are read-modify-write; loads are zero/sign-extended.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RD    | reading the addressed word (loads and sub-word stores)
// WR    | one-cycle memory write of the merged word
// RESP  | response held until resp_ready
module load_store_unit #(
   parameter int MEM_AW = 5,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [31:0]       mem_address,
   output logic [31:0]       mem_write_data,
   output logic              mem_write,
   input  logic [31:0]       mem_read_data
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   state_t      state_q, state_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic [31:0] wdata_q, wdata_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [31:0] rd_q, rd_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        req_err;

   // Select the addressed byte/half and extend it; words pass through.
   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] a, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{a, 3'b000} +: 8];
      h = w[{a[1], 4'b0000} +: 16];
      case (sz)
         2'b00:   extract = sgn ? {{24{b[7]}}, b} : {24'h0, b};
         2'b01:   extract = sgn ? {{16{h[15]}}, h} : {16'h0, h};
         2'b10:   extract = w;
         default: extract = '0;
      endcase
   endfunction

   // Replace one byte lane (or one half lane) of the read word with store data.
   function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] d,
                                         input logic is_half, input logic [1:0] a);
      logic [31:0] r;
      r = w;
      if (is_half) r[{a[1], 4'b0000} +: 16] = d;
      else         r[{a, 3'b000} +: 8] = d[7:0];
      return r;
   endfunction

   assign req_err = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                  || (req_addr[ADDR_W-1:MEM_AW+2] != '0);

   assign req_ready      = (state_q == IDLE) && !reset;
   assign resp_valid     = resp_valid_q;
   assign resp_rdata     = resp_rdata_q;
   assign resp_err       = resp_err_q;
   assign mem_address    = mem_addr_q;
   assign mem_write      = (state_q == WR);
   // rd_q and the latched fields are frozen during WR, so the word is stable all cycle.
   assign mem_write_data = (state_q != WR)  ? '0 :
                           (size_q == 2'b10) ? wdata_q :
                           merge(rd_q, wdata_q[15:0], size_q[0], addr_lo_q);

   // Next-state and datapath register updates.
   always_comb begin
      state_d      = state_q;
      addr_lo_d    = addr_lo_q;
      wdata_d      = wdata_q;
      write_d      = write_q;
      size_d       = size_q;
      signed_d     = signed_q;
      rd_d         = rd_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mem_addr_d   = mem_addr_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_lo_d = req_addr[1:0];
               wdata_d   = req_wdata;
               write_d   = req_write;
               size_d    = req_size;
               signed_d  = req_signed;
               if (req_err) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  mem_addr_d = 32'(req_addr[MEM_AW+1:2]);
                  state_d    = (req_write && req_size == 2'b10) ? WR : RD;
               end
            end
         end
         RD: begin
            rd_d = mem_read_data;
            if (write_q) begin
               state_d = WR;
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = extract(mem_read_data, size_q, addr_lo_q, signed_q);
            end
         end
         WR: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = '0;
         end
         RESP: begin
            if (resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_lo_q    <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         size_q       <= '0;
         signed_q     <= 1'b0;
         rd_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         mem_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         addr_lo_q    <= addr_lo_d;
         wdata_q      <= wdata_d;
         write_q      <= write_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         rd_q         <= rd_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         mem_addr_q   <= mem_addr_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 32-word behavioural memory.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [31:0] req_addr, req_wdata;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
   logic        mem_write;

   logic [31:0] mem [32];
   int          wr_cnt;
   logic [31:0] wr_addr, wr_data;
   int          checks, failures;

   load_store_unit #(.MEM_AW(5), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
      .req_signed(req_signed), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_write(mem_write),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_address[4:0]];

   // Memory writes on the negedge; log every write pulse.
   always @(negedge clk) begin
      if (mem_write) begin
         mem[mem_address[4:0]] = mem_write_data;
         wr_cnt  = wr_cnt + 1;
         wr_addr = mem_address;
         wr_data = mem_write_data;
      end
   end

   // Issue one request, measure latency, check response, then handshake.
   task automatic xact(input string name, input logic [31:0] addr, input logic [31:0] wd,
                       input logic wr, input logic [1:0] sz, input logic sgn,
                       input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
      int lat;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready);
      end
      req_addr = addr; req_wdata = wd; req_write = wr; req_size = sz; req_signed = sgn;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== exp_lat) begin
         failures++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      checks++;
      if (resp_rdata !== exp_rdata || resp_err !== exp_err) begin
         failures++;
         $display("FAIL %s response: got rdata=%h err=%b want rdata=%h err=%b",
                  name, resp_rdata, resp_err, exp_rdata, exp_err);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s after handshake: got valid=%b ready=%b want 0 1",
                  name, resp_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      checks++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 ||
          resp_err !== 1'b0 || mem_write !== 1'b0 || mem_address !== 32'h0 ||
          mem_write_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_values: got ready=%b valid=%b rdata=%h err=%b mw=%b ma=%h md=%h want all 0",
                  req_ready, resp_valid, resp_rdata, resp_err, mem_write, mem_address, mem_write_data);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release ready: got %b want 1", req_ready);
      end
   endtask

   task automatic test_loads();
      xact("lb_0D_s",  32'h0D, 32'h0, 1'b0, 2'b00, 1'b1, 2, 32'h0000007F, 1'b0);
      xact("lb_0E_s",  32'h0E, 32'h0, 1'b0, 2'b00, 1'b1, 2, 32'hFFFFFFF0, 1'b0);
      xact("lbu_0E",   32'h0E, 32'h0, 1'b0, 2'b00, 1'b0, 2, 32'h000000F0, 1'b0);
      xact("lh_0E_s",  32'h0E, 32'h0, 1'b0, 2'b01, 1'b1, 2, 32'hFFFF80F0, 1'b0);
      xact("lw_0C",    32'h0C, 32'h0, 1'b0, 2'b10, 1'b0, 2, 32'h80F07F12, 1'b0);
   endtask

   task automatic test_stores();
      int c0;
      c0 = wr_cnt;
      xact("sh_0E", 32'h0E, 32'hAAAABEEF, 1'b1, 2'b01, 1'b0, 3, 32'h0, 1'b0);
      checks++;
      if (wr_cnt - c0 !== 1 || wr_addr !== 32'd3 || wr_data !== 32'hBEEF7F12) begin
         failures++;
         $display("FAIL sh_write: got n=%0d addr=%h data=%h want n=1 addr=3 data=BEEF7F12",
                  wr_cnt - c0, wr_addr, wr_data);
      end
      mem[3] = 32'h80F07F12;
      xact("sb_0C", 32'h0C, 32'h00000055, 1'b1, 2'b00, 1'b0, 3, 32'h0, 1'b0);
      checks++;
      if (mem[3] !== 32'h80F07F55) begin
         failures++;
         $display("FAIL sb_word3: got %h want 80F07F55", mem[3]);
      end
      c0 = wr_cnt;
      xact("sw_7C", 32'h7C, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, 2, 32'h0, 1'b0);
      checks++;
      if (wr_cnt - c0 !== 1 || mem[31] !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL sw_word31: got n=%0d word=%h want n=1 word=DEADBEEF", wr_cnt - c0, mem[31]);
      end
      xact("lhu_7E", 32'h7E, 32'h0, 1'b0, 2'b01, 1'b0, 2, 32'h0000DEAD, 1'b0);
   endtask

   task automatic test_errors();
      int c0;
      c0 = wr_cnt;
      xact("err_lw_06",  32'h06, 32'h0, 1'b0, 2'b10, 1'b0, 1, 32'h0, 1'b1);
      xact("err_lh_03",  32'h03, 32'h0, 1'b0, 2'b01, 1'b1, 1, 32'h0, 1'b1);
      xact("err_size11", 32'h0C, 32'h0, 1'b0, 2'b11, 1'b0, 1, 32'h0, 1'b1);
      xact("err_lw_80",  32'h80, 32'h0, 1'b0, 2'b10, 1'b0, 1, 32'h0, 1'b1);
      xact("err_sw_80",  32'h80, 32'h1234, 1'b1, 2'b10, 1'b0, 1, 32'h0, 1'b1);
      checks++;
      if (wr_cnt !== c0) begin
         failures++;
         $display("FAIL err_no_write: got %0d writes want 0", wr_cnt - c0);
      end
   endtask

   task automatic test_backpressure();
      int n;
      req_addr = 32'h0C; req_wdata = 32'h0; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_addr = 32'h0D; req_size = 2'b00;
      n = 1;
      while (resp_valid !== 1'b1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (resp_valid !== 1'b1 || resp_rdata !== 32'h80F07F55 || resp_err !== 1'b0 ||
             req_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cyc%0d: got valid=%b rdata=%h err=%b ready=%b want 1 80F07F55 0 0",
                     i, resp_valid, resp_rdata, resp_err, req_ready);
         end
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_handshake: got valid=%b ready=%b want 0 1", resp_valid, req_ready);
      end
      // The pending byte load is accepted on this edge, only after the handshake.
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 1;
      while (resp_valid !== 1'b1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n !== 2 || resp_rdata !== 32'h0000007F) begin
         failures++;
         $display("FAIL bp_next_req: got lat=%0d rdata=%h want 2 0000007F", n, resp_rdata);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int c0;
      mem[3] = 32'h80F07F12;
      c0 = wr_cnt;
      req_addr = 32'h0C; req_wdata = 32'h99; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset = 1'b1;
      #1;
      checks++;
      if (mem_write !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0 ||
          mem_address !== 32'h0 || mem_write_data !== 32'h0 || resp_rdata !== 32'h0 ||
          resp_err !== 1'b0) begin
         failures++;
         $display("FAIL midreset_outputs: got mw=%b ready=%b valid=%b ma=%h md=%h want all 0",
                  mem_write, req_ready, resp_valid, mem_address, mem_write_data);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (wr_cnt !== c0 || mem[3] !== 32'h80F07F12 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_after: got writes=%0d word3=%h ready=%b valid=%b want 0 80F07F12 1 0",
                  wr_cnt - c0, mem[3], req_ready, resp_valid);
      end
      xact("lw_after_reset", 32'h0C, 32'h0, 1'b0, 2'b10, 1'b0, 2, 32'h80F07F12, 1'b0);
   endtask

   initial begin
      checks = 0; failures = 0; wr_cnt = 0; wr_addr = '0; wr_data = '0;
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      mem[3] = 32'h80F07F12;
      req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
      req_size = 2'b00; req_signed = 1'b0; resp_ready = 1'b0;
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
